// File: rtl/bus_cycle_sequencer_if.sv
// Machine-cycle request and per-T-state strobe bundle between the CPU core and the bus sequencer.
// slave = sequencer side, master = core/requester side.
interface bus_cycle_sequencer_if;
  logic       cyc_start;
  logic [2:0] cyc_type;
  logic       notWAIT;
  logic       notBUSRQ;
  logic       halt_req;
  logic       cyc_ready;
  logic       cyc_done;
  logic       latch_din;
  logic       r_inc;
  logic       PI_SelectAdt1;
  logic       notPI_Activate_Ad_high;
  logic       notPI_Activate_Ad_low;
  logic       notPI_Activate_Dt;
  logic       notPI_Flag_M1;
  logic       notPI_Flag_MREQ;
  logic       notPI_Flag_RD;
  logic       notPI_Flag_WR;
  logic       notPI_Flag_IORQ;
  logic       notPI_Flag_RFSH;
  logic       notPI_Flag_BUSAK;
  logic       notPI_Flag_HALT;

  modport slave (
    input  cyc_start, cyc_type, notWAIT, notBUSRQ, halt_req,
    output cyc_ready, cyc_done, latch_din, r_inc, PI_SelectAdt1,
           notPI_Activate_Ad_high, notPI_Activate_Ad_low, notPI_Activate_Dt,
           notPI_Flag_M1, notPI_Flag_MREQ, notPI_Flag_RD, notPI_Flag_WR,
           notPI_Flag_IORQ, notPI_Flag_RFSH, notPI_Flag_BUSAK, notPI_Flag_HALT
  );

  modport master (
    output cyc_start, cyc_type, notWAIT, notBUSRQ, halt_req,
    input  cyc_ready, cyc_done, latch_din, r_inc, PI_SelectAdt1,
           notPI_Activate_Ad_high, notPI_Activate_Ad_low, notPI_Activate_Dt,
           notPI_Flag_M1, notPI_Flag_MREQ, notPI_Flag_RD, notPI_Flag_WR,
           notPI_Flag_IORQ, notPI_Flag_RFSH, notPI_Flag_BUSAK, notPI_Flag_HALT
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// T-state sequencer: machine-cycle request -> Moore-decoded active-low bus strobes, T1 one clock after accept.
// Requester holds cyc_start until cyc_ready; WAIT stretches T2 via TW, BUSRQ parks the bus in BUSGNT.
module bus_cycle_sequencer #(
  parameter int IO_AUTO_WAIT = 1,
  parameter bit RFSH_ENABLE  = 1'b1
) (
  input  logic              CLK,
  input  logic              notRESET,
  bus_cycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_TW     = 3'd3,
    S_T3     = 3'd4,
    S_T4     = 3'd5,
    S_BUSGNT = 3'd6
  } state_t;

  localparam logic [1:0] AUTO_W      = 2'(IO_AUTO_WAIT);
  localparam logic [1:0] AUTO_RELOAD = 2'(IO_AUTO_WAIT - 1);

  state_t     state_q, state_d;
  logic [2:0] type_q, type_d;
  logic [1:0] auto_q, auto_d;
  logic       halt_q, halt_d;

  logic is_m1, is_mrd, is_mwr, is_iord, is_iowr, is_io, is_int;
  logic in_t1, in_t2w, in_t3, in_t4, in_cyc, in_bg;
  logic done;

  assign is_m1   = (type_q == 3'd0);
  assign is_mrd  = (type_q == 3'd1);
  assign is_mwr  = (type_q == 3'd2);
  assign is_iord = (type_q == 3'd3);
  assign is_iowr = (type_q == 3'd4);
  assign is_io   = is_iord | is_iowr;
  assign is_int  = (type_q >= 3'd5);

  assign in_t1  = (state_q == S_T1);
  assign in_t2w = (state_q == S_T2) | (state_q == S_TW);
  assign in_t3  = (state_q == S_T3);
  assign in_t4  = (state_q == S_T4);
  assign in_cyc = in_t1 | in_t2w | in_t3 | in_t4;
  assign in_bg  = (state_q == S_BUSGNT);

  assign done = in_t4 | (in_t3 & ~is_m1);

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_q <= S_IDLE;
      type_q  <= 3'd0;
      auto_q  <= 2'd0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      auto_q  <= auto_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    auto_d  = auto_q;
    halt_d  = bus.halt_req;
    case (state_q)
      S_T1: state_d = S_T2;
      S_T2: begin
        if (is_int) begin
          state_d = S_T3;
        end else if (is_io && (AUTO_W != 2'd0)) begin
          // Forced IO waits run first; notWAIT is only looked at in the last of them.
          state_d = S_TW;
          auto_d  = AUTO_RELOAD;
        end else if (!bus.notWAIT) begin
          state_d = S_TW;
        end else begin
          state_d = S_T3;
        end
      end
      S_TW: begin
        if (auto_q != 2'd0) begin
          auto_d = auto_q - 2'd1;
        end else if (bus.notWAIT) begin
          state_d = S_T3;
        end
      end
      S_T3:     if (is_m1) state_d = S_T4;
      S_BUSGNT: if (bus.notBUSRQ) state_d = S_IDLE;
      default:  ;
    endcase
    // Arbitration point: bus request beats a pending start.
    if ((state_q == S_IDLE) || done) begin
      if (!bus.notBUSRQ) begin
        state_d = S_BUSGNT;
      end else if (bus.cyc_start) begin
        state_d = S_T1;
        type_d  = bus.cyc_type;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  assign bus.cyc_ready = ((state_q == S_IDLE) | done) & bus.notBUSRQ;
  assign bus.cyc_done  = done;
  assign bus.latch_din = in_t3 & (is_m1 | is_mrd | is_iord);
  assign bus.r_inc     = in_t4 & is_m1;
  assign bus.PI_SelectAdt1 = is_m1 & (in_t3 | in_t4);

  assign bus.notPI_Activate_Ad_high = ~(in_cyc & ~is_int);
  assign bus.notPI_Activate_Ad_low  = ~(in_cyc & ~is_int);
  assign bus.notPI_Activate_Dt      = ~((is_mwr | is_iowr) & (in_t1 | in_t2w | in_t3));

  assign bus.notPI_Flag_M1   = ~(is_m1 & (in_t1 | in_t2w));
  assign bus.notPI_Flag_MREQ = ~((is_m1 & (in_t1 | in_t2w | (in_t3 & RFSH_ENABLE))) |
                                 ((is_mrd | is_mwr) & (in_t1 | in_t2w | in_t3)));
  assign bus.notPI_Flag_RD   = ~((is_m1 & (in_t1 | in_t2w)) |
                                 (is_mrd & (in_t1 | in_t2w | in_t3)) |
                                 (is_iord & (in_t2w | in_t3)));
  assign bus.notPI_Flag_WR   = ~((is_mwr | is_iowr) & (in_t2w | in_t3));
  assign bus.notPI_Flag_IORQ = ~(is_io & (in_t2w | in_t3));
  assign bus.notPI_Flag_RFSH = ~(RFSH_ENABLE & is_m1 & (in_t3 | in_t4));
  assign bus.notPI_Flag_BUSAK = ~in_bg;
  assign bus.notPI_Flag_HALT  = ~halt_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: per-T-state expected strobe vectors are queued when a
// cycle is requested and compared one per clock on the falling edge.
module tb_bus_cycle_sequencer;
  localparam int AUTO = 1;
  localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_T4 = 5, P_BG = 6;

  logic CLK = 1'b0;
  logic notRESET = 1'b0;
  bus_cycle_sequencer_if bus();

  bus_cycle_sequencer #(.IO_AUTO_WAIT(AUTO), .RFSH_ENABLE(1'b1)) dut (
    .CLK(CLK), .notRESET(notRESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  logic halt_exp = 1'b0;
  logic [14:0] sb[$];

  wire [14:0] obs = {bus.cyc_done, bus.latch_din, bus.r_inc, bus.PI_SelectAdt1,
                     bus.notPI_Activate_Ad_high, bus.notPI_Activate_Ad_low, bus.notPI_Activate_Dt,
                     bus.notPI_Flag_M1, bus.notPI_Flag_MREQ, bus.notPI_Flag_RD, bus.notPI_Flag_WR,
                     bus.notPI_Flag_IORQ, bus.notPI_Flag_RFSH, bus.notPI_Flag_BUSAK, bus.notPI_Flag_HALT};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected strobe vector for one T-state of a cycle of type t, written from the cycle tables.
  function automatic logic [14:0] exp_vec(input int ph, input logic [2:0] t);
    logic done = 0, latch = 0, rinc = 0, sel = 0;
    logic adh = 1, adl = 1, dt = 1, m1 = 1, mreq = 1, rd = 1, wr = 1, iorq = 1, rfsh = 1, busak = 1;
    bit t123 = (ph == P_T1 || ph == P_T2 || ph == P_TW || ph == P_T3);
    bit t23  = (ph == P_T2 || ph == P_TW || ph == P_T3);
    bit t12  = (ph == P_T1 || ph == P_T2 || ph == P_TW);
    if (ph == P_BG) busak = 0;
    if ((t123 || ph == P_T4) && t < 3'd5) begin adh = 0; adl = 0; end
    case (t)
      3'd0: begin
        if (t12) begin m1 = 0; mreq = 0; rd = 0; end
        if (ph == P_T3) begin latch = 1; sel = 1; mreq = 0; rfsh = 0; end
        if (ph == P_T4) begin sel = 1; rinc = 1; done = 1; rfsh = 0; end
      end
      3'd1: begin
        if (t123) begin mreq = 0; rd = 0; end
        if (ph == P_T3) begin latch = 1; done = 1; end
      end
      3'd2: begin
        if (t123) begin mreq = 0; dt = 0; end
        if (t23) wr = 0;
        if (ph == P_T3) done = 1;
      end
      3'd3: begin
        if (t23) begin iorq = 0; rd = 0; end
        if (ph == P_T3) begin latch = 1; done = 1; end
      end
      3'd4: begin
        if (t123) dt = 0;
        if (t23) begin iorq = 0; wr = 0; end
        if (ph == P_T3) done = 1;
      end
      default: if (ph == P_T3) done = 1;
    endcase
    return {done, latch, rinc, sel, adh, adl, dt, m1, mreq, rd, wr, iorq, rfsh, busak, ~halt_exp};
  endfunction

  task automatic idle_ticks(input int n);
    repeat (n) begin
      @(negedge CLK);
      chk("idle", obs, exp_vec(P_IDLE, 3'd0));
    end
  endtask

  // Called at a falling edge where the sequencer can accept; returns at the falling edge of the
  // last T-state so a following call chains back-to-back. brq_ph lowers notBUSRQ in that T-state.
  task automatic do_cycle(input logic [2:0] typ, input int nw, input int brq_ph);
    int ph[$];
    int nauto = (typ == 3'd3 || typ == 3'd4) ? AUTO : 0;
    int ntw   = (typ >= 3'd5) ? 0 : nw;
    logic [14:0] e;
    chk("accept_rdy", 32'(bus.cyc_ready), 32'd1);
    bus.cyc_start = 1'b1;
    bus.cyc_type  = typ;
    ph.push_back(P_T1);
    ph.push_back(P_T2);
    repeat (nauto + ntw) ph.push_back(P_TW);
    ph.push_back(P_T3);
    if (typ == 3'd0) ph.push_back(P_T4);
    foreach (ph[i]) sb.push_back(exp_vec(ph[i], typ));
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge CLK);
      if (i == 0) begin
        bus.cyc_start = 1'b0;
        bus.cyc_type  = ~typ;
      end
      e = sb.pop_front();
      chk($sformatf("type%0d_ph%0d", typ, i), 32'(obs), 32'(e));
      bus.notWAIT = !(i >= 1 + nauto && i < 1 + nauto + nw);
      if (brq_ph == i) bus.notBUSRQ = 1'b0;
    end
    bus.notWAIT = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cyc_start = 1'b0;
    bus.cyc_type  = 3'd0;
    bus.notWAIT   = 1'b1;
    bus.notBUSRQ  = 1'b1;
    bus.halt_req  = 1'b0;
    #2;
    chk("reset_vec", 32'(obs), 32'(exp_vec(P_IDLE, 3'd0)));
    chk("reset_rdy", 32'(bus.cyc_ready), 32'd1);
    @(negedge CLK);
    notRESET = 1'b1;
    idle_ticks(1);

    do_cycle(3'd0, 0, -1); idle_ticks(1);   // M1 fetch
    do_cycle(3'd1, 2, -1); idle_ticks(1);   // MEM RD with two waits
    do_cycle(3'd4, 0, -1); idle_ticks(1);   // IO WR, auto wait only
    do_cycle(3'd3, 1, -1); idle_ticks(1);   // IO RD, auto wait plus one
    do_cycle(3'd2, 1, -1); idle_ticks(1);   // MEM WR with one wait
    do_cycle(3'd6, 2, -1); idle_ticks(1);   // internal, WAIT ignored

    do_cycle(3'd0, 0, -1);                  // back-to-back chain
    do_cycle(3'd2, 0, -1);
    do_cycle(3'd5, 0, -1);
    idle_ticks(1);

    // Bus request raised in MEM RD T2; held start must not be taken while granted.
    do_cycle(3'd1, 0, 1);
    chk("rdy_busrq", 32'(bus.cyc_ready), 32'd0);
    bus.cyc_start = 1'b1;
    bus.cyc_type  = 3'd0;
    repeat (3) begin
      @(negedge CLK);
      chk("busgnt", 32'(obs), 32'(exp_vec(P_BG, 3'd0)));
      chk("rdy_bg", 32'(bus.cyc_ready), 32'd0);
    end
    bus.notBUSRQ = 1'b1;
    @(negedge CLK);
    chk("bus_release", 32'(obs), 32'(exp_vec(P_IDLE, 3'd0)));
    do_cycle(3'd0, 0, -1);
    idle_ticks(1);

    // HALT flag is a registered copy of halt_req and does not block cycles.
    bus.halt_req = 1'b1;
    @(negedge CLK);
    halt_exp = 1'b1;
    chk("halt_on", 32'(obs), 32'(exp_vec(P_IDLE, 3'd0)));
    do_cycle(3'd1, 0, -1);
    bus.halt_req = 1'b0;
    @(negedge CLK);
    halt_exp = 1'b0;
    chk("halt_off", 32'(obs), 32'(exp_vec(P_IDLE, 3'd0)));

    // Asynchronous reset in the middle of M1 T3.
    bus.halt_req  = 1'b1;
    bus.cyc_start = 1'b1;
    bus.cyc_type  = 3'd0;
    @(negedge CLK);
    bus.cyc_start = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #2;
    notRESET = 1'b0;
    #1;
    chk("midrst_vec", 32'(obs), 32'(exp_vec(P_IDLE, 3'd0)));
    chk("midrst_rdy", 32'(bus.cyc_ready), 32'd1);
    bus.halt_req = 1'b0;
    @(negedge CLK);
    notRESET = 1'b1;
    idle_ticks(2);
    do_cycle(3'd1, 0, -1);
    idle_ticks(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
